// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing FSM: drives datapath selects, enables and memory strobes.
// Optional performance counters are built when MULTICYCLE_PERF_EN is defined.
module multicycle_controller #(
   parameter int WAIT_LIMIT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        memReady,
   output logic        pcWrite,
   output logic        irWrite,
   output logic        iorD,
   output logic        memRead,
   output logic        memWrite,
   output logic        memtoReg,
   output logic        regWrite,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic        PCSource,
   output logic [3:0]  state,
   output logic [1:0]  trapCause,
   output logic [31:0] cycleCount,
   output logic [31:0] instretCount
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_I_EXEC    = 4'd9,
      S_TRAP      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t      state_q, state_d;
   logic [1:0]  cause_q, cause_d;
   logic [15:0] wait_q, wait_d;
   logic        waiting;
   logic        timeout;

   // Memory handshake: a transfer completes in the cycle its strobe is high
   // and memReady is high; memReady low means hold the strobe and wait.
   always_comb begin
      waiting = ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                 (state_q == S_MEM_WRITE)) && !memReady;
      timeout = waiting && (WAIT_LIMIT != 0) && (wait_q == 16'(WAIT_LIMIT - 1));
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_FETCH:     if (memReady) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_ITYPE:     state_d = S_I_EXEC;
               OP_BRANCH:    state_d = S_BRANCH;
               default: begin
                  state_d = S_TRAP;
                  cause_d = 2'b01;
               end
            endcase
         end
         S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (memReady) state_d = S_MEM_WB;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: if (memReady) state_d = S_FETCH;
         S_R_EXEC:    state_d = S_ALU_WB;
         S_I_EXEC:    state_d = S_ALU_WB;
         S_ALU_WB:    state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_TRAP:      state_d = S_TRAP;
         default:     state_d = S_FETCH;
      endcase
      if (timeout) begin
         state_d = S_TRAP;
         cause_d = 2'b10;
      end
      // Leaving a wait state always clears the counter, so clearing on entry falls out.
      wait_d = (waiting && !timeout) ? wait_q + 16'd1 : 16'd0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         cause_q <= 2'b00;
         wait_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      iorD     = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      memtoReg = 1'b0;
      regWrite = 1'b0;
      ALUSrcA  = 2'b00;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSource = 1'b0;
      case (state_q)
         S_FETCH: begin
            memRead = 1'b1;
            ALUSrcB = 2'b01;
            irWrite = memReady;
            pcWrite = memReady;
         end
         S_DECODE: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b10;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
         end
         S_MEM_READ: begin
            memRead = 1'b1;
            iorD    = 1'b1;
         end
         S_MEM_WB: begin
            regWrite = 1'b1;
            memtoReg = 1'b1;
         end
         S_MEM_WRITE: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
         end
         S_R_EXEC: begin
            ALUSrcA = 2'b01;
            ALUOp   = 2'b10;
         end
         S_I_EXEC: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            ALUOp   = 2'b11;
         end
         S_ALU_WB: regWrite = 1'b1;
         S_BRANCH: begin
            ALUSrcA  = 2'b01;
            ALUOp    = 2'b01;
            PCSource = 1'b1;
            pcWrite  = zero;
         end
         default: ;
      endcase
      // Reset aborts the instruction in flight, including any write strobe.
      if (reset) begin
         pcWrite  = 1'b0;
         irWrite  = 1'b0;
         memRead  = 1'b0;
         memWrite = 1'b0;
         regWrite = 1'b0;
      end
   end

   assign state     = state_q;
   assign trapCause = cause_q;

`ifdef MULTICYCLE_PERF_EN
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] instret_q, instret_d;
   logic        retire;

   always_comb begin
      retire = (state_d == S_FETCH) &&
               ((state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
                (state_q == S_ALU_WB) || (state_q == S_BRANCH));
      cycle_d   = (state_q != S_TRAP) ? cycle_q + 32'd1 : cycle_q;
      instret_d = retire ? instret_q + 32'd1 : instret_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_q   <= 32'd0;
         instret_q <= 32'd0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   assign cycleCount   = cycle_q;
   assign instretCount = instret_q;
`else
   assign cycleCount   = 32'd0;
   assign instretCount = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with WAIT_LIMIT=4; counter expectations follow MULTICYCLE_PERF_EN.
module tb_multicycle_controller;

   logic        clock;
   logic        reset;
   logic [6:0]  opcode;
   logic        zero;
   logic        memReady;
   logic        pcWrite, irWrite, iorD, memRead, memWrite, memtoReg, regWrite;
   logic [1:0]  ALUSrcA, ALUSrcB, ALUOp;
   logic        PCSource;
   logic [3:0]  state;
   logic [1:0]  trapCause;
   logic [31:0] cycleCount, instretCount;

   int tests_run;
   int tests_failed;

`ifdef MULTICYCLE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   multicycle_controller #(.WAIT_LIMIT(4)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
      .pcWrite(pcWrite), .irWrite(irWrite), .iorD(iorD), .memRead(memRead),
      .memWrite(memWrite), .memtoReg(memtoReg), .regWrite(regWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .state(state), .trapCause(trapCause),
      .cycleCount(cycleCount), .instretCount(instretCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset    = 1'b1;
      memReady = 1'b0;
      zero     = 1'b0;
      opcode   = 7'd0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      memReady = 1'b1;
      tick();
      tick();
      #1;
      tests_run++;
      if (state !== 4'd0 || trapCause !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_state: state=%0d cause=%0d, expected state=0 cause=0", state, trapCause);
      end
      tests_run++;
      if ({pcWrite, irWrite, memRead, memWrite, regWrite} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_strobes: got %b, expected 00000", {pcWrite, irWrite, memRead, memWrite, regWrite});
      end
      tests_run++;
      if (cycleCount !== 32'd0 || instretCount !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_counters: cycle=%0d instret=%0d, expected 0 0", cycleCount, instretCount);
      end
      reset = 1'b0;
      #1;
      tests_run++;
      if ({memRead, irWrite, pcWrite} !== 3'b111) begin
         tests_failed++;
         $display("FAIL fetch_after_reset: memRead/irWrite/pcWrite=%b, expected 111", {memRead, irWrite, pcWrite});
      end
   endtask

   // Shared by R-type and I-type: check state, regWrite and selects per cycle.
   task automatic test_alu(input logic [6:0] op, input logic [3:0] exec_state, input logic [5:0] exec_sel);
      logic [3:0] exp_st  [5];
      logic [5:0] exp_sel [5];
      logic       exp_rw  [5];
      exp_st  = '{4'd0, 4'd1, exec_state, 4'd7, 4'd0};
      exp_sel = '{6'b000100, 6'b101000, exec_sel, 6'b000000, 6'b000100};
      exp_rw  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      opcode   = op;
      memReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests_run++;
         if (state !== exp_st[i] || regWrite !== exp_rw[i] || {ALUSrcA, ALUSrcB, ALUOp} !== exp_sel[i]) begin
            tests_failed++;
            $display("FAIL alu_op%b_cyc%0d: state=%0d rw=%b sel=%b, expected state=%0d rw=%b sel=%b",
                     op, i, state, regWrite, {ALUSrcA, ALUSrcB, ALUOp}, exp_st[i], exp_rw[i], exp_sel[i]);
         end
         if (i == 4) begin
            tests_run++;
            if (instretCount !== (PERF ? 32'd1 : 32'd0) || cycleCount !== (PERF ? 32'd4 : 32'd0)) begin
               tests_failed++;
               $display("FAIL alu_counters: instret=%0d cycle=%0d, expected %0d %0d",
                        instretCount, cycleCount, PERF ? 1 : 0, PERF ? 4 : 0);
            end
         end
         tick();
      end
   endtask

   task automatic test_lw_wait;
      logic [3:0] exp_st [9];
      logic       mr     [9];
      exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
      mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      opcode = 7'b0000011;
      for (int i = 0; i < 9; i++) begin
         memReady = mr[i];
         #1;
         tests_run++;
         if (state !== exp_st[i] || memtoReg !== (i == 7) || regWrite !== (i == 7)) begin
            tests_failed++;
            $display("FAIL lw_cyc%0d: state=%0d memtoReg=%b regWrite=%b, expected state=%0d wb=%b",
                     i, state, memtoReg, regWrite, exp_st[i], (i == 7));
         end
         if (i >= 3 && i <= 6) begin
            tests_run++;
            if (memRead !== 1'b1 || iorD !== 1'b1) begin
               tests_failed++;
               $display("FAIL lw_read_strobe_cyc%0d: memRead=%b iorD=%b, expected 1 1", i, memRead, iorD);
            end
         end
         if (i == 8) begin
            tests_run++;
            if (instretCount !== (PERF ? 32'd1 : 32'd0) || cycleCount !== (PERF ? 32'd8 : 32'd0)) begin
               tests_failed++;
               $display("FAIL lw_counters: instret=%0d cycle=%0d, expected %0d %0d",
                        instretCount, cycleCount, PERF ? 1 : 0, PERF ? 8 : 0);
            end
         end
         tick();
      end
   endtask

   task automatic test_branch;
      logic [3:0] exp_st [7];
      logic       zv     [7];
      logic       exp_pw [7];
      exp_st = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8, 4'd0};
      zv     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_pw = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      opcode   = 7'b1100011;
      memReady = 1'b1;
      for (int i = 0; i < 7; i++) begin
         zero = zv[i];
         #1;
         tests_run++;
         if (state !== exp_st[i] || pcWrite !== exp_pw[i] || PCSource !== (exp_st[i] == 4'd8)) begin
            tests_failed++;
            $display("FAIL beq_cyc%0d: state=%0d pcWrite=%b PCSource=%b, expected state=%0d pcWrite=%b",
                     i, state, pcWrite, PCSource, exp_st[i], exp_pw[i]);
         end
         if (i == 6) begin
            tests_run++;
            if (instretCount !== (PERF ? 32'd2 : 32'd0)) begin
               tests_failed++;
               $display("FAIL beq_instret: got %0d, expected %0d", instretCount, PERF ? 2 : 0);
            end
         end
         tick();
      end
   endtask

   task automatic test_timeout(input logic late_ready);
      logic [3:0] exp_st [8];
      logic       mr     [8];
      exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, late_ready ? 4'd0 : 4'd10};
      mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, late_ready, 1'b0};
      do_reset();
      opcode = 7'b0100011;
      for (int i = 0; i < 8; i++) begin
         memReady = mr[i];
         #1;
         tests_run++;
         if (state !== exp_st[i] || memWrite !== (i >= 3 && i <= 6)) begin
            tests_failed++;
            $display("FAIL sw_late%b_cyc%0d: state=%0d memWrite=%b, expected state=%0d memWrite=%b",
                     late_ready, i, state, memWrite, exp_st[i], (i >= 3 && i <= 6));
         end
         if (i == 7) begin
            tests_run++;
            if (trapCause !== (late_ready ? 2'b00 : 2'b10)) begin
               tests_failed++;
               $display("FAIL sw_late%b_cause: got %b, expected %b", late_ready, trapCause, late_ready ? 2'b00 : 2'b10);
            end
            tests_run++;
            if (instretCount !== ((PERF && late_ready) ? 32'd1 : 32'd0) || cycleCount !== (PERF ? 32'd7 : 32'd0)) begin
               tests_failed++;
               $display("FAIL sw_late%b_counters: instret=%0d cycle=%0d, expected %0d %0d", late_ready,
                        instretCount, cycleCount, (PERF && late_ready) ? 1 : 0, PERF ? 7 : 0);
            end
         end
         tick();
      end
   endtask

   task automatic test_illegal;
      do_reset();
      opcode   = 7'b1110011;
      memReady = 1'b1;
      tick();
      tick();
      zero = 1'b1;
      #1;
      tests_run++;
      if (state !== 4'd10 || trapCause !== 2'b01) begin
         tests_failed++;
         $display("FAIL illegal_trap: state=%0d cause=%b, expected 10 01", state, trapCause);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         tests_run++;
         if (state !== 4'd10 || trapCause !== 2'b01 ||
             {pcWrite, irWrite, memRead, memWrite, regWrite} !== 5'b0 ||
             cycleCount !== (PERF ? 32'd2 : 32'd0)) begin
            tests_failed++;
            $display("FAIL trap_hold_cyc%0d: state=%0d cause=%b strobes=%b cycle=%0d, expected 10 01 00000 %0d",
                     i, state, trapCause, {pcWrite, irWrite, memRead, memWrite, regWrite}, cycleCount, PERF ? 2 : 0);
         end
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      tests_run++;
      if (state !== 4'd0 || trapCause !== 2'b00) begin
         tests_failed++;
         $display("FAIL trap_reset: state=%0d cause=%b, expected 0 00", state, trapCause);
      end
   endtask

   task automatic test_reset_mid_write;
      do_reset();
      opcode   = 7'b0100011;
      memReady = 1'b1;
      tick();
      tick();
      tick();
      memReady = 1'b0;
      #1;
      tests_run++;
      if (state !== 4'd5 || memWrite !== 1'b1) begin
         tests_failed++;
         $display("FAIL midwr_setup: state=%0d memWrite=%b, expected 5 1", state, memWrite);
      end
      tick();
      reset = 1'b1;
      #1;
      tests_run++;
      if (state !== 4'd5 || memWrite !== 1'b0) begin
         tests_failed++;
         $display("FAIL midwr_suppress: state=%0d memWrite=%b, expected 5 0", state, memWrite);
      end
      tick();
      reset = 1'b0;
      #1;
      tests_run++;
      if (state !== 4'd0 || cycleCount !== 32'd0) begin
         tests_failed++;
         $display("FAIL midwr_after: state=%0d cycle=%0d, expected 0 0", state, cycleCount);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      opcode       = 7'd0;
      zero         = 1'b0;
      memReady     = 1'b0;
      test_reset();
      test_alu(7'b0110011, 4'd6, 6'b010010);
      test_alu(7'b0010011, 4'd9, 6'b011011);
      test_lw_wait();
      test_branch();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_illegal();
      test_reset_mid_write();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle RV32I datapath variant: it drives every mux select, register-enable and memory strobe so that one shared ALU and one unified instruction/data memory port are reused across the cycles of each instruction. Supported opcodes are R-type, I-type ALU, lw, sw and beq. Memory accesses use a ready handshake with a bounded wait. The block sits beside the ALUControl block, which consumes its `ALUOp`.

## Interface
- `WAIT_LIMIT`, 16: maximum cycles a memory state may wait for `memReady` before trapping; 0 disables the timeout.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 7: instruction register bits [6:0]; valid from DECODE onward.
- `zero` input 1: ALU zero flag.
- `memReady` input 1: memory completes the current read/write this cycle.
- `pcWrite` output 1: PC register load enable.
- `irWrite` output 1: instruction register (and oldPC register) load enable.
- `iorD` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `memRead` output 1: memory read strobe.
- `memWrite` output 1: memory write strobe.
- `memtoReg` output 1: writeback select; 1 = memory data register, 0 = ALUOut.
- `regWrite` output 1: register file write enable.
- `ALUSrcA` output 2: 00 = PC, 01 = rs1, 10 = oldPC.
- `ALUSrcB` output 2: 00 = rs2, 01 = constant 4, 10 = immediate.
- `ALUOp` output 2: 00 = add, 01 = branch compare, 10 = R-type funct, 11 = I-type funct.
- `PCSource` output 1: 0 = ALU result, 1 = ALUOut (branch target).
- `state` output 4: current state encoding, for debug.
- `trapCause` output 2: 00 = none, 01 = illegal opcode, 10 = memory timeout.
- `cycleCount` output 32: performance counter (see Configuration).
- `instretCount` output 32: performance counter (see Configuration).

## Operation
- Moore FSM. Outputs are decoded from the registered state. The exceptions are `pcWrite` in FETCH and BRANCH, and `irWrite` in FETCH, which also depend on `memReady` or `zero`.
- Unlisted outputs are 0 in every state.
- **FETCH (0):** `memRead`=1, `iorD`=0, `ALUSrcA`=00, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=0. `irWrite`=`pcWrite`=`memReady`. Go to DECODE on `memReady`; otherwise stay.
- **DECODE (1):** `ALUSrcA`=10, `ALUSrcB`=10, `ALUOp`=00; this computes the branch target into ALUOut. Next state by opcode:
  - 0000011 or 0100011 → MEM_ADDR
  - 0110011 → R_EXEC
  - 0010011 → I_EXEC
  - 1100011 → BRANCH
  - anything else → TRAP with cause 01
- **MEM_ADDR (2):** `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00. lw → MEM_READ; sw → MEM_WRITE.
- **MEM_READ (3):** `memRead`=1, `iorD`=1. Go to MEM_WB on `memReady`.
- **MEM_WB (4):** `regWrite`=1, `memtoReg`=1, then FETCH.
- **MEM_WRITE (5):** `memWrite`=1, `iorD`=1. Go to FETCH on `memReady`.
- **R_EXEC (6):** `ALUSrcA`=01, `ALUSrcB`=00, `ALUOp`=10, then ALU_WB.
- **I_EXEC (9):** `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=11, then ALU_WB.
- **ALU_WB (7):** `regWrite`=1, `memtoReg`=0, then FETCH.
- **BRANCH (8):** `ALUSrcA`=01, `ALUSrcB`=00, `ALUOp`=01, `PCSource`=1, `pcWrite`=`zero`, then FETCH.
- **TRAP (10):** all strobes and enables 0. This state is terminal until `reset`. `trapCause` holds its value and is sticky.
- **Wait counter:**
  - A 16-bit counter clears on entry to FETCH, MEM_READ or MEM_WRITE, and increments each cycle the FSM stays there with `memReady`=0.
  - If `WAIT_LIMIT`≠0 and the counter reaches `WAIT_LIMIT`−1 with `memReady` still 0, the next state is TRAP with cause 10. No strobe is issued in TRAP.
  - `memReady` in the same cycle as the limit wins: normal transition, no trap.

## Timing
- **Reset:** while `reset`=1 the next state is FETCH, `trapCause`=00, the wait counter is 0 and the counters are 0. All strobes and enables are forced to 0 during the reset cycle.
- **Zero-wait latency** (cycles from FETCH entry to the next FETCH entry):
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-type: 4
  - beq: 3
- Each memory wait cycle adds 1.
- `memReady` is sampled only in FETCH, MEM_READ and MEM_WRITE; it is ignored elsewhere.
- `opcode` is sampled in DECODE and MEM_ADDR only.
- `reset` asserted mid-instruction aborts it. A write strobe active in that cycle is suppressed.
- Encodings 11–15 are unreachable; if entered, the next state is FETCH.

## Configuration
- **`MULTICYCLE_PERF_EN` defined:**
  - `cycleCount` increments every non-reset cycle outside TRAP.
  - `instretCount` increments on every transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB or BRANCH.
  - Both wrap modulo 2^32 and clear on `reset`.
- **`MULTICYCLE_PERF_EN` undefined:** both ports are tied to 0 and no counter registers are built. The port list is identical in both builds.

## Test plan
- R-type add with `memReady` held at 1 → states 0,1,6,7,0; `regWrite`=1 only in cycle 4; `instretCount`=1 after it (with the macro).
- lw with `memReady` low for 3 cycles in MEM_READ → states 0,1,2,3,3,3,3,4,0; `memtoReg`=`regWrite`=1 in state 4 only.
- beq with `zero`=1, then beq with `zero`=0 → `pcWrite`=1 with `PCSource`=1 in BRANCH for the first only; 3 cycles each.
- opcode 1110011 → DECODE then TRAP, `trapCause`=01; all strobes stay 0 for 20 cycles; `reset` returns the FSM to FETCH with `trapCause`=00.
- With `WAIT_LIMIT`=4 and `memReady`=0 in MEM_WRITE → TRAP after 4 cycles, `trapCause`=10. Repeat with `memReady` rising on the 4th cycle → FETCH, no trap.
- `reset` asserted during MEM_WRITE → `memWrite`=0 in that cycle and FETCH next; `cycleCount`=0.
